// File: rtl/clock_phase_generator.sv
// Two-phase non-overlapping i4004 clock-enable generator (clk1/clk2) with run/stop on period boundaries.
// Optional single-period step control is enabled by defining MCS4_CLKGEN_STEP_EN.
module clock_phase_generator #(
  parameter int PHI1_WIDTH  = 8,
  parameter int GAP12_WIDTH = 4,
  parameter int PHI2_WIDTH  = 8,
  parameter int GAP21_WIDTH = 4
) (
  input  logic sysclk,
  input  logic reset,
  input  logic run,
`ifdef MCS4_CLKGEN_STEP_EN
  input  logic step,
`endif
  output logic clk1,
  output logic clk2,
  output logic cycle_end,
  output logic running
);

  if (PHI1_WIDTH < 1 || PHI1_WIDTH > 255) begin : g_bad_phi1
    $error("PHI1_WIDTH must be 1..255");
  end
  if (GAP12_WIDTH < 1 || GAP12_WIDTH > 255) begin : g_bad_gap12
    $error("GAP12_WIDTH must be 1..255");
  end
  if (PHI2_WIDTH < 1 || PHI2_WIDTH > 255) begin : g_bad_phi2
    $error("PHI2_WIDTH must be 1..255");
  end
  if (GAP21_WIDTH < 1 || GAP21_WIDTH > 255) begin : g_bad_gap21
    $error("GAP21_WIDTH must be 1..255");
  end

  localparam logic [7:0] LD_PHI1  = 8'(PHI1_WIDTH - 1);
  localparam logic [7:0] LD_GAP12 = 8'(GAP12_WIDTH - 1);
  localparam logic [7:0] LD_PHI2  = 8'(PHI2_WIDTH - 1);
  localparam logic [7:0] LD_GAP21 = 8'(GAP21_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PHI1  = 3'd1,
    S_GAP12 = 3'd2,
    S_PHI2  = 3'd3,
    S_GAP21 = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       clk1_q, clk2_q, cycle_end_q, running_q;
  logic       start_req;

`ifdef MCS4_CLKGEN_STEP_EN
  logic step_q;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  // A step edge only counts while run is low; the FSM further limits it to IDLE.
  assign start_req = run | (step & ~step_q);
`else
  assign start_req = run;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (start_req) begin
          state_d = S_PHI1;
          cnt_d   = LD_PHI1;
        end
      end
      S_PHI1: begin
        if (cnt_q == 8'd0) begin
          state_d = S_GAP12;
          cnt_d   = LD_GAP12;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP12: begin
        if (cnt_q == 8'd0) begin
          state_d = S_PHI2;
          cnt_d   = LD_PHI2;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_PHI2: begin
        if (cnt_q == 8'd0) begin
          state_d = S_GAP21;
          cnt_d   = LD_GAP21;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP21: begin
        // run is sampled only here, so a stop never truncates a period
        if (cnt_q == 8'd0) begin
          if (run) begin
            state_d = S_PHI1;
            cnt_d   = LD_PHI1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they change with the state and never glitch.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      clk1_q      <= 1'b0;
      clk2_q      <= 1'b0;
      cycle_end_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk1_q      <= (state_d == S_PHI1);
      clk2_q      <= (state_d == S_PHI2);
      cycle_end_q <= (state_d == S_GAP21) && (cnt_d == 8'd0);
      running_q   <= (state_d != S_IDLE);
    end
  end

  assign clk1      = clk1_q;
  assign clk2      = clk2_q;
  assign cycle_end = cycle_end_q;
  assign running   = running_q;

endmodule

// File: doc/clock_phase_generator.md
# clock_phase_generator

- Generates the two-phase, non-overlapping i4004 clock enables `clk1`/`clk2` from `sysclk`.
- Sits directly upstream of the CPU's internal timing generator, which consumes `clk1`/`clk2` as sysclk-synchronous phase enables, and upstream of every other MCS-4 chip model.
- Provides run/stop control that always stops on a complete clock period.
- Phase widths are parameterised in sysclk cycles.

## Interface
Parameters:
- `PHI1_WIDTH`, default 8: sysclk cycles `clk1` is high; legal 1..255.
- `GAP12_WIDTH`, default 4: sysclk cycles both low between `clk1` fall and `clk2` rise; legal 1..255.
- `PHI2_WIDTH`, default 8: sysclk cycles `clk2` is high; legal 1..255.
- `GAP21_WIDTH`, default 4: sysclk cycles both low between `clk2` fall and next `clk1` rise; legal 1..255.

Ports:
- `sysclk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `run` input 1: level; 1 = free-running clock periods, 0 = stop at the end of the current period.
- `clk1` output 1: phase-1 enable, registered.
- `clk2` output 1: phase-2 enable, registered.
- `cycle_end` output 1: one-sysclk pulse on the last sysclk of each GAP21.
- `running` output 1: high whenever the state is not IDLE.
- `step` input 1: only present with `MCS4_CLKGEN_STEP_EN`; see Configuration.

## Operation
- States: IDLE, PHI1, GAP12, PHI2, GAP21.
  - An 8-bit down-counter is loaded with width-1 on entry to each state.
  - The state advances when the counter is 0.
- Transitions:
  - IDLE→PHI1 when `run`=1, or when a step is granted.
  - PHI1→GAP12→PHI2→GAP21 unconditionally on counter expiry.
  - GAP21→PHI1 if `run`=1 at the expiring edge, else GAP21→IDLE.
- Decode:
  - `clk1`=1 exactly while the state is PHI1; `clk2`=1 exactly while the state is PHI2.
  - Both are registered with the state, so they are glitch-free and never high together.
- `cycle_end`=1 exactly while the state is GAP21 and the counter is 0.
- Stopping:
  - `run` falling at any point in a period never truncates that period; the period completes through GAP21.
  - `run` re-rising before GAP21 expires continues with no idle cycle.
- Reset, asynchronous and possible mid-period:
  - Immediately forces the state to IDLE, the counter to 0, and `clk1`=`clk2`=`cycle_end`=`running`=0.
  - Clears the step edge detector.
- Illegal parameter values (0 or >255) are an elaboration error via `$error`.

## Timing
- Period = PHI1_WIDTH+GAP12_WIDTH+PHI2_WIDTH+GAP21_WIDTH sysclk cycles; 24 with the defaults.
- Start latency: `clk1` rises on the first sysclk edge at which the state is IDLE and `run`=1.
- With `run` high at reset release, `clk1` rises on the first edge after release.
- Back-to-back periods: `clk1` rises on the edge after the last GAP21 cycle, so `cycle_end` and `clk1` are never high together.
- Every output holds 0 through reset and in IDLE.
- `running` rises on the same edge as `clk1` and falls on the edge GAP21 expires into IDLE.

## Configuration
- Macro `MCS4_CLKGEN_STEP_EN`.
- Defined:
  - Adds input `step`.
  - A rising edge of `step`, via a registered previous value, detected while in IDLE with `run`=0 grants exactly one full period, then returns to IDLE.
  - Step edges while not in IDLE, or while `run`=1, are ignored and not queued.
- Undefined:
  - No `step` port and no step logic.
  - IDLE exits only on `run`.

## Test plan
- Reset, then `run`=1 with defaults → `clk1` high 8, low 4, `clk2` high 8, low 4; 24-cycle period; `clk1`&`clk2` never both 1.
- `run` dropped on the 2nd cycle of PHI2 → `clk2` still completes 8 cycles, GAP21 4 cycles with `cycle_end` on its last cycle, then IDLE with `running`=0 and no further `clk1`.
- `reset` asserted mid-PHI1, asynchronous to the sysclk edge → `clk1`=0 immediately; after release with `run`=1, `clk1` rises on the first edge.
- Parameters 1/1/1/1 → `clk1`,0,`clk2`,0 repeating with a 4-cycle period; `cycle_end` every 4th cycle.
- `run` toggled 0→1 during GAP21 of a stopping period → the next `clk1` rises with no idle gap.
- With `MCS4_CLKGEN_STEP_EN`: `run`=0, two `step` pulses 5 cycles apart → exactly one 24-cycle period; a `step` pulse in IDLE afterwards → exactly one more.
